id_ex_stage: RTL and testbench

Pipeline register between the Decode and Execute stages of the MIPS pipeline. It registers the control word produced by `main_control` (regdst, ULAsrc, memtoreg, regwrite, memread, memwrite, branch, ULAop) together with the ID-stage operands. It also detects load-use hazards and inserts bubbles for them. It answers branch flushes from downstream and keeps a saturating count of inserted load-use bubbles for performance monitoring.

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: carries the main_control word and ID operands into EX,
// inserts one-cycle bubbles on load-use hazards and flushes, and counts stall bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              regdst,
    input  logic              ULAsrc,
    input  logic              memtoreg,
    input  logic              regwrite,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              branch,
    input  logic [1:0]        ULAop,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_regdst,
    output logic              ex_ULAsrc,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [1:0]        ex_ULAop,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              vld_p1;
    logic [6:0]        ctrl_p1;
    logic [1:0]        ulaop_p1;
    logic [4:0]        rs_p1, rt_p1, rd_p1;
    logic [DATA_W-1:0] rs_data_p1, rt_data_p1, imm_p1, pc4_p1;
    logic [CNT_W-1:0]  cnt_q;

    logic id_uses_rt;
    logic load_use;
    logic bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // ID stage: hazard detection against the instruction currently in EX
    always_comb begin
        id_uses_rt = regdst | memwrite | branch;
        load_use   = vld_p1 & ctrl_p1[4] & (rt_p1 != 5'd0) & id_valid &
                     ((rt_p1 == id_rs) | (id_uses_rt & (rt_p1 == id_rt)));
        stall      = load_use & ~flush;
        bubble     = flush | load_use | ~id_valid;
    end

    // ID -> EX boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            ulaop_p1   <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rd_p1      <= '0;
            rs_data_p1 <= '0;
            rt_data_p1 <= '0;
            imm_p1     <= '0;
            pc4_p1     <= '0;
            cnt_q      <= '0;
        end else begin
            if (bubble) begin
                vld_p1     <= 1'b0;
                ctrl_p1    <= '0;
                ulaop_p1   <= '0;
                rs_p1      <= '0;
                rt_p1      <= '0;
                rd_p1      <= '0;
                rs_data_p1 <= '0;
                rt_data_p1 <= '0;
                imm_p1     <= '0;
                pc4_p1     <= '0;
            end else begin
                vld_p1     <= 1'b1;
                ctrl_p1    <= {branch, memwrite, memread, regwrite, memtoreg, ULAsrc, regdst};
                ulaop_p1   <= ULAop;
                rs_p1      <= id_rs;
                rt_p1      <= id_rt;
                rd_p1      <= id_rd;
                rs_data_p1 <= id_rs_data;
                rt_data_p1 <= id_rt_data;
                imm_p1     <= id_imm;
                pc4_p1     <= id_pc4;
            end
            if (stall)
                cnt_q <= sat_inc(cnt_q);
        end
    end

    assign ex_valid    = vld_p1;
    assign ex_regdst   = ctrl_p1[0];
    assign ex_ULAsrc   = ctrl_p1[1];
    assign ex_memtoreg = ctrl_p1[2];
    assign ex_regwrite = ctrl_p1[3];
    assign ex_memread  = ctrl_p1[4];
    assign ex_memwrite = ctrl_p1[5];
    assign ex_branch   = ctrl_p1[6];
    assign ex_ULAop    = ulaop_p1;
    assign ex_rs       = rs_p1;
    assign ex_rt       = rt_p1;
    assign ex_rd       = rd_p1;
    assign ex_rs_data  = rs_data_p1;
    assign ex_rt_data  = rt_data_p1;
    assign ex_imm      = imm_p1;
    assign ex_pc4      = pc4_p1;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: passthrough, load-use stalls, flush priority,
// register $0, counter saturation and asynchronous reset behaviour.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic              regdst, ULAsrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]        ULAop;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic              ex_regdst, ex_ULAsrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0]        ex_ULAop;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .regdst(regdst), .ULAsrc(ULAsrc), .memtoreg(memtoreg), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .branch(branch), .ULAop(ULAop),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_regdst(ex_regdst), .ex_ULAsrc(ex_ULAsrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_ULAop(ex_ULAop),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        {regdst, ULAsrc, memtoreg, regwrite, memread, memwrite, branch} = '0;
        ULAop = 2'b00;
    endtask

    task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
        clear_ctrl();
        id_valid = 1'b1; ULAsrc = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; memread = 1'b1;
        id_rs = rs; id_rt = rt; id_rd = 5'd0;
        id_rs_data = 32'h100; id_rt_data = 32'h0; id_imm = 32'h4; id_pc4 = 32'h1000;
    endtask

    task automatic drive_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_ctrl();
        id_valid = 1'b1; regdst = 1'b1; regwrite = 1'b1; ULAop = 2'b10;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = 32'h11; id_rt_data = 32'h22; id_imm = 32'h33; id_pc4 = 32'h44;
    endtask

    task automatic drive_sw(input logic [4:0] rs, input logic [4:0] rt);
        clear_ctrl();
        id_valid = 1'b1; ULAsrc = 1'b1; memwrite = 1'b1;
        id_rs = rs; id_rt = rt; id_rd = 5'd0;
        id_rs_data = 32'h200; id_rt_data = 32'h55; id_imm = 32'h8; id_pc4 = 32'h2000;
    endtask

    initial begin
        // Reset held with random inputs across clock edges
        reset = 1'b0;
        flush = 1'b0;
        id_valid = 1'b1;
        {regdst, ULAsrc, memtoreg, regwrite, memread, memwrite, branch} = 7'($urandom);
        ULAop = 2'($urandom);
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_pc4 = $urandom;
        tick();
        tick();
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_cnt", 64'(stall_cnt), 64'd0);
        check("rst_ctrl", 64'({ex_regdst, ex_ULAsrc, ex_memtoreg, ex_regwrite, ex_memread,
                              ex_memwrite, ex_branch, ex_ULAop}), 64'd0);
        check("rst_regs", 64'({ex_rs, ex_rt, ex_rd}), 64'd0);
        check("rst_data", 64'(ex_rs_data | ex_rt_data | ex_imm | ex_pc4), 64'd0);

        // R-format passthrough
        reset = 1'b1;
        drive_r(5'd3, 5'd4, 5'd5);
        #1;
        check("r_stall", 64'(stall), 64'd0);
        tick();
        check("r_valid", 64'(ex_valid), 64'd1);
        check("r_ctrl", 64'({ex_regdst, ex_ULAsrc, ex_memtoreg, ex_regwrite, ex_memread,
                            ex_memwrite, ex_branch}), 64'b1001000);
        check("r_ulaop", 64'(ex_ULAop), 64'd2);
        check("r_regs", 64'({ex_rs, ex_rt, ex_rd}), 64'({5'd3, 5'd4, 5'd5}));
        check("r_rs_data", 64'(ex_rs_data), 64'h11);
        check("r_rt_data", 64'(ex_rt_data), 64'h22);
        check("r_imm_pc4", 64'({ex_imm, ex_pc4}), 64'({32'h33, 32'h44}));

        // Mid-cycle asynchronous reset clears outputs before the next edge
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 64'(ex_valid), 64'd0);
        check("arst_data", 64'(ex_rs_data), 64'd0);
        check("arst_regwrite", 64'(ex_regwrite), 64'd0);
        reset = 1'b1;
        id_valid = 1'b0;
        tick();
        check("invalid_bubble", 64'(ex_valid), 64'd0);

        // Classic load-use: lw $8 then R-format reading $8
        drive_lw(5'd1, 5'd8);
        tick();
        check("lw_memread", 64'(ex_memread), 64'd1);
        check("lw_rt", 64'(ex_rt), 64'd8);
        drive_r(5'd8, 5'd2, 5'd3);
        #1;
        check("lu_stall", 64'(stall), 64'd1);
        tick();
        check("lu_bubble_valid", 64'(ex_valid), 64'd0);
        check("lu_bubble_ctrl", 64'({ex_regwrite, ex_regdst, ex_ULAop}), 64'd0);
        check("lu_bubble_rs", 64'(ex_rs), 64'd0);
        check("lu_bubble_data", 64'(ex_rs_data), 64'd0);
        check("lu_stall_drop", 64'(stall), 64'd0);
        check("lu_cnt", 64'(stall_cnt), 64'd1);
        tick();
        check("lu_replay_valid", 64'(ex_valid), 64'd1);
        check("lu_replay_regs", 64'({ex_rs, ex_rt, ex_rd}), 64'({5'd8, 5'd2, 5'd3}));
        check("lu_cnt_hold", 64'(stall_cnt), 64'd1);

        // lw $0 never creates a hazard
        drive_lw(5'd1, 5'd0);
        tick();
        drive_r(5'd0, 5'd0, 5'd4);
        #1;
        check("r0_stall", 64'(stall), 64'd0);

        // lw $9 followed by sw (rt source), lw (rt dest), invalid ID slot
        drive_lw(5'd2, 5'd9);
        tick();
        drive_sw(5'd1, 5'd9);
        #1;
        check("sw_rt_stall", 64'(stall), 64'd1);
        drive_lw(5'd3, 5'd9);
        #1;
        check("lw_rt_nostall", 64'(stall), 64'd0);
        drive_r(5'd9, 5'd9, 5'd1);
        id_valid = 1'b0;
        #1;
        check("invalid_nostall", 64'(stall), 64'd0);
        tick();
        check("invalid_cnt", 64'(stall_cnt), 64'd1);
        check("invalid_valid", 64'(ex_valid), 64'd0);

        // Flush beats load-use
        drive_lw(5'd1, 5'd7);
        tick();
        drive_r(5'd7, 5'd1, 5'd2);
        flush = 1'b1;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        tick();
        flush = 1'b0;
        check("flush_bubble", 64'(ex_valid), 64'd0);
        check("flush_bubble_rs", 64'(ex_rs), 64'd0);
        check("flush_cnt", 64'(stall_cnt), 64'd1);

        // Saturation: 260 load-use pairs from count 1
        for (int i = 0; i < 260; i++) begin
            drive_lw(5'd1, 5'd10);
            tick();
            drive_r(5'd10, 5'd2, 5'd3);
            tick();
            if (i == 199)
                check("sat_mid", 64'(stall_cnt), 64'd201);
        end
        check("sat_cnt", 64'(stall_cnt), 64'd255);
        drive_lw(5'd1, 5'd10);
        tick();
        drive_r(5'd10, 5'd2, 5'd3);
        #1;
        check("sat_stall", 64'(stall), 64'd1);
        tick();
        check("sat_nowrap", 64'(stall_cnt), 64'd255);

        // Reset during a stall: stall drops with ex_memread, no residual bubble
        drive_lw(5'd1, 5'd8);
        tick();
        drive_r(5'd8, 5'd5, 5'd6);
        #1;
        check("rs_stall_pre", 64'(stall), 64'd1);
        reset = 1'b0;
        #1;
        check("rs_stall_drop", 64'(stall), 64'd0);
        check("rs_memread", 64'(ex_memread), 64'd0);
        check("rs_cnt", 64'(stall_cnt), 64'd0);
        reset = 1'b1;
        tick();
        check("rs_capture_valid", 64'(ex_valid), 64'd1);
        check("rs_capture_regs", 64'({ex_rs, ex_rt, ex_rd}), 64'({5'd8, 5'd5, 5'd6}));

        // All-zero control word is captured as a valid instruction
        clear_ctrl();
        id_valid = 1'b1;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd6;
        id_rs_data = 32'hDEADBEEF; id_rt_data = 32'h0; id_imm = 32'h0; id_pc4 = 32'h10;
        tick();
        check("zero_op_valid", 64'(ex_valid), 64'd1);
        check("zero_op_ctrl", 64'({ex_regdst, ex_ULAsrc, ex_memtoreg, ex_regwrite, ex_memread,
                                  ex_memwrite, ex_branch, ex_ULAop}), 64'd0);
        check("zero_op_data", 64'({ex_rd, ex_rs_data}), 64'({5'd6, 32'hDEADBEEF}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
